// File: rtl/mem_arb_pkg.sv
// Shared types and constants for the memory port arbiter and its response pipe.
package mem_arb_pkg;

   typedef enum logic {
      OWNER_F = 1'b0,
      OWNER_D = 1'b1
   } mem_owner_t;

   typedef enum logic {
      UNLOCKED = 1'b0,
      LOCKED   = 1'b1
   } lock_state_t;

   typedef struct packed {
      logic       valid;
      mem_owner_t owner;
   } rsp_tag_t;

   localparam logic [1:0] MEM_BE_NONE = 2'b00;

endpackage

// File: rtl/mem_rsp_pipe.sv
// Read-return tag pipeline: tracks who issued each read and steers mem_rdata
// back to that requester when the memory presents it.
module mem_rsp_pipe
   import mem_arb_pkg::*;
#(
   parameter int DATA_W       = 16,
   parameter int READ_LATENCY = 1
) (
   input  logic              clk,
   input  logic              rst_async_n,
   input  logic              push_valid,
   input  mem_owner_t        push_owner,
   input  logic [DATA_W-1:0] mem_rdata,
   output logic              f_rvalid,
   output logic [DATA_W-1:0] f_rdata,
   output logic              d_rvalid,
   output logic [DATA_W-1:0] d_rdata
);

   rsp_tag_t          tag_r [READ_LATENCY];
   rsp_tag_t          out_tag_s;
   logic [DATA_W-1:0] f_hold_r;
   logic [DATA_W-1:0] d_hold_r;

   // Tag shift register; stage 0 is loaded in the issue cycle.
   always_ff @(posedge clk or negedge rst_async_n) begin
      if (!rst_async_n) begin
         for (int i = 0; i < READ_LATENCY; i++) begin
            tag_r[i] <= '{valid: 1'b0, owner: OWNER_F};
         end
      end else begin
         tag_r[0] <= '{valid: push_valid, owner: push_owner};
         for (int i = 1; i < READ_LATENCY; i++) begin
            tag_r[i] <= tag_r[i-1];
         end
      end
   end

   // Output stage: the last tag lines up with the cycle mem_rdata is valid.
   always_comb begin
      out_tag_s = tag_r[READ_LATENCY-1];
      f_rvalid  = out_tag_s.valid && (out_tag_s.owner == OWNER_F);
      d_rvalid  = out_tag_s.valid && (out_tag_s.owner == OWNER_D);
      f_rdata   = f_rvalid ? mem_rdata : f_hold_r;
      d_rdata   = d_rvalid ? mem_rdata : d_hold_r;
   end

   // Each requester keeps its last returned word until its next read returns.
   always_ff @(posedge clk or negedge rst_async_n) begin
      if (!rst_async_n) begin
         f_hold_r <= '0;
         d_hold_r <= '0;
      end else begin
         if (f_rvalid) begin
            f_hold_r <= mem_rdata;
         end
         if (d_rvalid) begin
            d_hold_r <= mem_rdata;
         end
      end
   end

endmodule

// File: rtl/mem_port_arbiter.sv
// Shares one pipelined synchronous memory port between fetch (F) and
// load/store (D): round-robin with a fetch lock for multi-word fetches.
module mem_port_arbiter
   import mem_arb_pkg::*;
#(
   parameter int ADDR_W       = 13,
   parameter int DATA_W       = 16,
   parameter int READ_LATENCY = 1
) (
   input  logic              clk,
   input  logic              rst_async_n,
   input  logic              f_req,
   input  logic              f_lock,
   input  logic [ADDR_W-1:0] f_addr,
   output logic              f_gnt,
   output logic              f_rvalid,
   output logic [DATA_W-1:0] f_rdata,
   input  logic              d_req,
   input  logic              d_we,
   input  logic [1:0]        d_be,
   input  logic [ADDR_W-1:0] d_addr,
   input  logic [DATA_W-1:0] d_wdata,
   output logic              d_gnt,
   output logic              d_rvalid,
   output logic [DATA_W-1:0] d_rdata,
   output logic [ADDR_W-1:0] mem_addr,
   output logic              mem_we,
   output logic [1:0]        mem_be,
   output logic [DATA_W-1:0] mem_wdata,
   input  logic [DATA_W-1:0] mem_rdata
);

   lock_state_t       lock_state_r;
   lock_state_t       lock_next_s;
   mem_owner_t        last_winner_r;
   logic [ADDR_W-1:0] addr_hold_r;
   logic              lock_active_s;
   logic              f_win_s;
   logic              d_win_s;
   logic              push_valid_s;
   mem_owner_t        push_owner_s;

   // Winner selection; grants are forced low while reset is asserted.
   always_comb begin
      f_win_s       = 1'b0;
      d_win_s       = 1'b0;
      lock_active_s = (lock_state_r == LOCKED) && f_lock;
      if (!rst_async_n) begin
         f_win_s = 1'b0;
         d_win_s = 1'b0;
      end else if (f_req && d_req) begin
         if (lock_active_s || (last_winner_r == OWNER_D)) begin
            f_win_s = 1'b1;
         end else begin
            d_win_s = 1'b1;
         end
      end else begin
         f_win_s = f_req;
         d_win_s = d_req;
      end
   end

   // Memory port drive follows the winner in its grant cycle.
   always_comb begin
      mem_addr  = addr_hold_r;
      mem_we    = 1'b0;
      mem_be    = MEM_BE_NONE;
      mem_wdata = '0;
      if (f_win_s) begin
         mem_addr = f_addr;
      end else if (d_win_s) begin
         mem_addr  = d_addr;
         mem_we    = d_we;
         mem_be    = d_we ? d_be : MEM_BE_NONE;
         mem_wdata = d_we ? d_wdata : '0;
      end else begin
         mem_addr = addr_hold_r;
      end
      f_gnt        = f_win_s;
      d_gnt        = d_win_s;
      push_valid_s = f_win_s || (d_win_s && !d_we);
      push_owner_s = d_win_s ? OWNER_D : OWNER_F;
   end

   // Lock next-state: enter on a locked fetch grant, leave when f_lock drops.
   always_comb begin
      lock_next_s = lock_state_r;
      case (lock_state_r)
         UNLOCKED: lock_next_s = (f_win_s && f_lock) ? LOCKED : UNLOCKED;
         LOCKED:   lock_next_s = f_lock ? LOCKED : UNLOCKED;
         default:  lock_next_s = UNLOCKED;
      endcase
   end

   // Arbitration state and the held memory address.
   always_ff @(posedge clk or negedge rst_async_n) begin
      if (!rst_async_n) begin
         lock_state_r  <= UNLOCKED;
         last_winner_r <= OWNER_D;
         addr_hold_r   <= '0;
      end else begin
         lock_state_r <= lock_next_s;
         addr_hold_r  <= mem_addr;
         if (f_win_s) begin
            last_winner_r <= OWNER_F;
         end else if (d_win_s) begin
            last_winner_r <= OWNER_D;
         end
      end
   end

   mem_rsp_pipe #(
      .DATA_W       (DATA_W),
      .READ_LATENCY (READ_LATENCY)
   ) u_rsp_pipe (
      .clk         (clk),
      .rst_async_n (rst_async_n),
      .push_valid  (push_valid_s),
      .push_owner  (push_owner_s),
      .mem_rdata   (mem_rdata),
      .f_rvalid    (f_rvalid),
      .f_rdata     (f_rdata),
      .d_rvalid    (d_rvalid),
      .d_rdata     (d_rdata)
   );

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Bench: drives two arbiters (READ_LATENCY 1 and 3) with identical stimulus,
// each against its own memory, and scoreboards grants and read returns.
module tb_mem_port_arbiter;
   import mem_arb_pkg::*;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic        rst_async_n;
   logic        f_req, f_lock, d_req, d_we;
   logic [12:0] f_addr, d_addr;
   logic [1:0]  d_be;
   logic [15:0] d_wdata;

   logic        f_gnt_o [2], d_gnt_o [2], f_rvalid_o [2], d_rvalid_o [2], mem_we_o [2];
   logic [15:0] f_rdata_o [2], d_rdata_o [2], mem_wdata_o [2], mem_rdata_i [2];
   logic [12:0] mem_addr_o [2];
   logic [1:0]  mem_be_o [2];

   int tests = 0;
   int fails = 0;

   function automatic logic [15:0] init_word(input int i);
      return 16'((i * 433) ^ 23130);
   endfunction

   for (genvar g = 0; g < 2; g++) begin : inst
      localparam int LAT = (g == 0) ? 1 : 3;
      logic [15:0] mem [0:8191];
      logic [15:0] rd_pipe [LAT];

      initial begin
         for (int i = 0; i < 8192; i++) mem[i] = init_word(i);
         for (int i = 0; i < LAT; i++) rd_pipe[i] = 16'h0000;
      end

      always @(posedge clk) begin
         if (mem_we_o[g]) begin
            if (mem_be_o[g][1]) mem[mem_addr_o[g]][15:8] <= mem_wdata_o[g][15:8];
            if (mem_be_o[g][0]) mem[mem_addr_o[g]][7:0]  <= mem_wdata_o[g][7:0];
         end
         rd_pipe[0] <= mem[mem_addr_o[g]];
         for (int i = 1; i < LAT; i++) rd_pipe[i] <= rd_pipe[i-1];
      end

      assign mem_rdata_i[g] = rd_pipe[LAT-1];

      mem_port_arbiter #(.ADDR_W(13), .DATA_W(16), .READ_LATENCY(LAT)) dut (
         .clk(clk), .rst_async_n(rst_async_n),
         .f_req(f_req), .f_lock(f_lock), .f_addr(f_addr), .f_gnt(f_gnt_o[g]),
         .f_rvalid(f_rvalid_o[g]), .f_rdata(f_rdata_o[g]),
         .d_req(d_req), .d_we(d_we), .d_be(d_be), .d_addr(d_addr), .d_wdata(d_wdata),
         .d_gnt(d_gnt_o[g]), .d_rvalid(d_rvalid_o[g]), .d_rdata(d_rdata_o[g]),
         .mem_addr(mem_addr_o[g]), .mem_we(mem_we_o[g]), .mem_be(mem_be_o[g]),
         .mem_wdata(mem_wdata_o[g]), .mem_rdata(mem_rdata_i[g])
      );
   end

   task automatic check(input int k, input string name, input logic [63:0] act, input logic [63:0] exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL [lat%0d] %s: got %0h expected %0h at %0t", (k == 0) ? 1 : 3, name, act, exp, $time);
      end
   endtask

   // Reference model: abstract memory, arbitration history and expected returns.
   typedef struct { int due; logic own_d; logic [15:0] data; } exp_t;
   exp_t        q1 [$];
   exp_t        q3 [$];
   logic [15:0] ref_mem [0:8191];
   logic [15:0] mf [2];
   logic [15:0] md [2];
   mem_owner_t  m_last;
   logic        m_locked;
   logic [12:0] m_last_addr;
   int          cyc;
   logic        g_f, g_d;

   initial for (int i = 0; i < 8192; i++) ref_mem[i] = init_word(i);

   task automatic chk_zero(input int k);
      check(k, "rst_ctl", {f_gnt_o[k], d_gnt_o[k], f_rvalid_o[k], d_rvalid_o[k], mem_we_o[k], mem_be_o[k]}, 64'd0);
      check(k, "rst_addr", mem_addr_o[k], 64'd0);
      check(k, "rst_wdata", mem_wdata_o[k], 64'd0);
      check(k, "rst_rdata", {f_rdata_o[k], d_rdata_o[k]}, 64'd0);
   endtask

   task automatic chk_rsp(input int k);
      exp_t e;
      bit   hit = 1'b0;
      if (k == 0) begin
         if (q1.size() > 0 && q1[0].due == cyc) begin e = q1.pop_front(); hit = 1'b1; end
      end else begin
         if (q3.size() > 0 && q3[0].due == cyc) begin e = q3.pop_front(); hit = 1'b1; end
      end
      if (hit) begin
         check(k, "rvalid_owner", {f_rvalid_o[k], d_rvalid_o[k]}, e.own_d ? 64'd1 : 64'd2);
         if (e.own_d) md[k] = e.data;
         else mf[k] = e.data;
      end else begin
         check(k, "no_rvalid", {f_rvalid_o[k], d_rvalid_o[k]}, 64'd0);
      end
      check(k, "f_rdata", f_rdata_o[k], mf[k]);
      check(k, "d_rdata", d_rdata_o[k], md[k]);
   endtask

   // Monitor: mid-cycle, compare DUT outputs with the model and advance it.
   always @(negedge clk) begin
      logic ef, ed;
      exp_t e;
      if (!rst_async_n) begin
         m_last = OWNER_D; m_locked = 1'b0; m_last_addr = 13'd0;
         q1.delete(); q3.delete();
         g_f = 1'b0; g_d = 1'b0;
         for (int k = 0; k < 2; k++) begin mf[k] = 16'd0; md[k] = 16'd0; chk_zero(k); end
      end else begin
         cyc++;
         chk_rsp(0);
         chk_rsp(1);
         if (f_req && d_req) begin
            ef = (m_locked && f_lock) || (m_last == OWNER_D);
            ed = !ef;
         end else begin
            ef = f_req;
            ed = d_req;
         end
         for (int k = 0; k < 2; k++) begin
            check(k, "f_gnt", f_gnt_o[k], ef);
            check(k, "d_gnt", d_gnt_o[k], ed);
            check(k, "mem_we", mem_we_o[k], ed && d_we);
            check(k, "mem_be", mem_be_o[k], (ed && d_we) ? d_be : 2'b00);
            check(k, "mem_addr", mem_addr_o[k], ef ? f_addr : (ed ? d_addr : m_last_addr));
            if (ed && d_we) check(k, "mem_wdata", mem_wdata_o[k], d_wdata);
         end
         if (ef || (ed && !d_we)) begin
            e.own_d = ed;
            e.data  = ref_mem[ef ? f_addr : d_addr];
            e.due   = cyc + 1; q1.push_back(e);
            e.due   = cyc + 3; q3.push_back(e);
         end
         if (ed && d_we) begin
            if (d_be[1]) ref_mem[d_addr][15:8] = d_wdata[15:8];
            if (d_be[0]) ref_mem[d_addr][7:0]  = d_wdata[7:0];
         end
         if (ef) begin m_last = OWNER_F; m_last_addr = f_addr; end
         if (ed) begin m_last = OWNER_D; m_last_addr = d_addr; end
         m_locked = m_locked ? f_lock : (ef && f_lock);
         g_f = ef;
         g_d = ed;
      end
   end

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   // Stimulus: directed scenarios followed by randomized traffic.
   initial begin
      int  n, nf;
      bit  fdone;
      cyc = 0;
      rst_async_n = 1'b0;
      f_req = 1'b1; f_lock = 1'b0; f_addr = 13'h0001;
      d_req = 1'b1; d_we = 1'b0; d_be = 2'b00; d_addr = 13'h0002; d_wdata = 16'h0000;
      repeat (3) @(posedge clk);
      #3 rst_async_n = 1'b1;

      // Both requesting after reset: F first, then strict alternation.
      repeat (8) begin
         step();
         if (g_f) f_addr = f_addr + 13'd1;
         if (g_d) d_addr = d_addr + 13'd1;
      end

      // Locked three-word fetch against a waiting load.
      f_lock = 1'b1; f_addr = 13'h0010; d_addr = 13'h0040;
      nf = 0; n = 0;
      while (nf < 3 && n < 20) begin
         step(); n++;
         if (g_f) begin nf++; f_addr = f_addr + 13'd1; end
      end
      check(0, "lock_fetch_done", nf, 64'd3);
      f_lock = 1'b0;
      @(negedge clk);
      for (int k = 0; k < 2; k++) check(k, "lock_drop_d_gnt", d_gnt_o[k], 64'd1);
      step();
      f_req = 1'b0; d_req = 1'b0;
      step();

      // High-byte write then read-back of the same word.
      d_req = 1'b1; d_we = 1'b1; d_be = 2'b10; d_addr = 13'h0100; d_wdata = 16'hBEEF;
      @(negedge clk);
      for (int k = 0; k < 2; k++) check(k, "wr_be", {mem_we_o[k], mem_be_o[k]}, 64'h6);
      step();
      d_we = 1'b0; d_be = 2'b00;
      step();
      d_req = 1'b0;
      repeat (3) step();
      for (int k = 0; k < 2; k++) check(k, "rd_hi_byte", d_rdata_o[k][15:8], 64'hBE);

      // Interleaved reads F@1, D@2, F@3.
      f_req = 1'b1; f_addr = 13'd1; d_req = 1'b1; d_addr = 13'd2;
      fdone = 1'b0; n = 0;
      while (!fdone && n < 20) begin
         step(); n++;
         if (g_d) d_req = 1'b0;
         if (g_f) begin
            if (f_addr == 13'd1) f_addr = 13'd3;
            else begin f_req = 1'b0; fdone = 1'b1; end
         end
      end
      check(0, "interleave_done", fdone, 64'd1);
      repeat (5) step();

      // Reset one cycle after a load read grant: the return must be dropped.
      d_req = 1'b1; d_we = 1'b0; d_addr = 13'd5;
      n = 0;
      do begin step(); n++; end while (!g_d && n < 20);
      check(0, "rst_rd_granted", g_d, 64'd1);
      d_req = 1'b0;
      #1 rst_async_n = 1'b0;
      #1;
      for (int k = 0; k < 2; k++) chk_zero(k);
      repeat (2) @(posedge clk);
      #3 rst_async_n = 1'b1;
      repeat (6) step();

      // Lock without a fetch request does not hold off loads.
      f_lock = 1'b1; f_req = 1'b0; d_req = 1'b1; d_we = 1'b0; d_addr = 13'd8;
      repeat (6) begin
         step();
         if (g_d) d_addr = d_addr + 13'd1;
      end
      f_lock = 1'b0; d_req = 1'b0;
      step();

      // Randomized traffic with holds, withdrawals and lock toggling.
      repeat (1500) begin
         step();
         if (g_f || !f_req) begin
            f_req  = ($urandom_range(99) < 60);
            f_addr = 13'($urandom_range(31));
         end else if ($urandom_range(99) < 5) begin
            f_req = 1'b0;
         end
         if (g_d || !d_req) begin
            d_req   = ($urandom_range(99) < 60);
            d_we    = 1'($urandom_range(1));
            d_be    = 2'($urandom_range(3));
            d_addr  = 13'($urandom_range(31));
            d_wdata = 16'($urandom);
         end else if ($urandom_range(99) < 5) begin
            d_req = 1'b0;
         end
         if ($urandom_range(3) == 0) f_lock = ~f_lock;
      end

      f_req = 1'b0; d_req = 1'b0; f_lock = 1'b0;
      repeat (6) step();
      check(0, "drain_q", q1.size(), 64'd0);
      check(1, "drain_q", q3.size(), 64'd0);
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
